bit_serial_alu: RTL

//   Multi-cycle ALU that processes one operand bit per clock, LSB first, through a single
//   bit slice: arithmetic extender (yi), logic extender (xi) and full adder with a carry flop.

---
 rtl/bit_serial_alu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: one-slice serial ALU. It processes one operand bit per clock,
// LSB first. Each bit passes through an arithmetic extender, a logic extender
// and a full adder whose carry is held in a flop. An operation takes WIDTH+1
// cycles from the accepted start to the done pulse.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_m,
  input  logic             op_s1,
  input  logic             op_s0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_sh_r;
  logic [CNT_W-1:0]   count_r;
  logic               carry_r;
  logic               cin_msb_r;
  logic               m_r;
  logic               s1_r;
  logic               s0_r;

  logic               slice_y_s;
  logic               slice_x_s;
  logic               slice_sum_s;
  logic               slice_carry_s;
  logic               accept_s;
  logic               last_bit_s;

  // Arithmetic extender. B, ~B, 0 or all-ones is fed to the adder.
  function automatic logic arith_ext(input logic m, input logic s1,
                                     input logic s0, input logic bi);
    logic y;
    if (m) begin
      case ({s1, s0})
        2'b00:   y = 1'b0;
        2'b01:   y = bi;
        2'b10:   y = ~bi;
        2'b11:   y = 1'b1;
        default: y = 1'b0;
      endcase
    end else begin
      y = 1'b0;
    end
    return y;
  endfunction

  // Logic extender. In arithmetic mode it passes A through to the adder.
  function automatic logic logic_ext(input logic m, input logic s1,
                                     input logic s0, input logic ai,
                                     input logic bi);
    logic x;
    if (m) begin
      x = ai;
    end else begin
      case ({s1, s0})
        2'b00:   x = ai & bi;
        2'b01:   x = ai | bi;
        2'b10:   x = ai ^ bi;
        2'b11:   x = ~ai;
        default: x = 1'b0;
      endcase
    end
    return x;
  endfunction

  // Majority of three gives the full-adder carry.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Bit slice on the current LSBs of the operand shift registers.
  // A start that arrives while done is still high is refused. This stops a
  // back-to-back request from slipping in on the done cycle.
  always_comb begin
    slice_y_s     = 1'b0;
    slice_x_s     = 1'b0;
    slice_sum_s   = 1'b0;
    slice_carry_s = 1'b0;
    slice_y_s     = arith_ext(m_r, s1_r, s0_r, b_sh_r[0]);
    slice_x_s     = logic_ext(m_r, s1_r, s0_r, a_sh_r[0], b_sh_r[0]);
    slice_sum_s   = slice_x_s ^ slice_y_s ^ carry_r;
    if (m_r) begin
      slice_carry_s = maj3(slice_x_s, slice_y_s, carry_r);
    end else begin
      slice_carry_s = 1'b0;
    end
    accept_s   = (state_r == ST_IDLE) && start && !done;
    last_bit_s = (count_r == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus datapath registers. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      res_sh_r  <= '0;
      count_r   <= '0;
      carry_r   <= 1'b0;
      cin_msb_r <= 1'b0;
      m_r       <= 1'b0;
      s1_r      <= 1'b0;
      s0_r      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            m_r     <= op_m;
            s1_r    <= op_s1;
            s0_r    <= op_s0;
            carry_r <= op_m & ~op_s0;
            count_r <= '0;
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          res_sh_r <= {slice_sum_s, res_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= slice_carry_s;
          count_r  <= count_r + CNT_W'(1);
          if (last_bit_s) begin
            // Keep the carry into the MSB so overflow can be computed later.
            cin_msb_r <= carry_r;
            busy      <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          result  <= res_sh_r;
          zero    <= (res_sh_r == '0);
          cout    <= m_r & carry_r;
          ovf     <= m_r & (carry_r ^ cin_msb_r);
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
